sad_sweep_scheduler: RTL and testbench

SAD_SWEEP_SCHEDULER -- requirements
Module: sad_sweep_scheduler

---
 rtl/sad_sweep_scheduler.sv | 105 ++++++++++
 tb/tb_sad_sweep_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_sweep_scheduler.sv
// Line-rate sweep scheduler for a SAD stereo engine: walks every column and disparity
// through the compare/aggregate/select/write pipeline and queues at most one pending line.
module sad_sweep_scheduler #(
   parameter  int unsigned IMG_WIDTH     = 320,
   parameter  int unsigned MAX_DISPARITY = 31,
   parameter  int unsigned X_FIRST       = 1,
   localparam int unsigned XW            = 10,
   localparam int unsigned DW            = 6,
   localparam int unsigned CW            = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          line_start,
   input  logic          stall,
   output logic          cmp_en,
   output logic          agg_en,
   output logic          sel_en,
   output logic          wr_en,
   output logic          px_last,
   output logic [XW-1:0] proc_x,
   output logic [DW-1:0] d,
   output logic          bank_sel,
   output logic          busy,
   output logic          pending,
   output logic          line_done,
   output logic [CW-1:0] overrun_cnt
);

   localparam int unsigned   X_LAST    = IMG_WIDTH - MAX_DISPARITY - 2;
   localparam logic [XW-1:0] X_FIRST_V = XW'(X_FIRST);
   localparam logic [XW-1:0] X_LAST_V  = XW'(X_LAST);
   localparam logic [DW-1:0] D_MAX_V   = DW'(MAX_DISPARITY);

   typedef enum logic [2:0] {IDLE, COMPARE, AGGREGATE, SELECT, WRITE} state_t;

   state_t state;
   logic   px_end;
   logic   line_end;

   // Stage strobes are the state decode gated by stall, so a stall silences them in the same cycle.
   assign cmp_en    = (state == COMPARE)   && !stall;
   assign agg_en    = (state == AGGREGATE) && !stall;
   assign sel_en    = (state == SELECT)    && !stall;
   assign wr_en     = (state == WRITE)     && !stall;
   assign px_end    = wr_en && (d == D_MAX_V);
   assign line_end  = px_end && (proc_x == X_LAST_V);
   assign px_last   = px_end;
   assign line_done = line_end;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         proc_x      <= X_FIRST_V;
         d           <= '0;
         bank_sel    <= 1'b0;
         pending     <= 1'b0;
         overrun_cnt <= '0;
      end else begin
         // The queued line is consumed at end of line; a start arriving that same cycle re-queues.
         if (line_end) begin
            pending <= pending & line_start;
         end else if (line_start && (state != IDLE)) begin
            if (!pending) begin
               pending <= 1'b1;
            end else if (overrun_cnt != '1) begin
               overrun_cnt <= overrun_cnt + CW'(1);
            end
         end

         if (!stall) begin
            case (state)
               IDLE: begin
                  if (line_start) begin
                     state  <= COMPARE;
                     proc_x <= X_FIRST_V;
                     d      <= '0;
                  end
               end
               COMPARE:   state <= AGGREGATE;
               AGGREGATE: state <= SELECT;
               SELECT:    state <= WRITE;
               WRITE: begin
                  if (d < D_MAX_V) begin
                     d     <= d + DW'(1);
                     state <= COMPARE;
                  end else begin
                     d <= '0;
                     if (proc_x < X_LAST_V) begin
                        proc_x <= proc_x + XW'(1);
                        state  <= COMPARE;
                     end else begin
                        proc_x   <= X_FIRST_V;
                        bank_sel <= ~bank_sel;
                        state    <= (pending || line_start) ? COMPARE : IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sad_sweep_scheduler.sv
// Directed bench for sad_sweep_scheduler with a line scoreboard checked on every line_done.
module tb_sad_sweep_scheduler;

   localparam int unsigned IMG_W = 60;
   localparam int unsigned MD    = 31;
   localparam int unsigned XF    = 1;
   localparam int unsigned XL    = IMG_W - MD - 2;
   localparam int unsigned NPX   = XL - XF + 1;
   localparam int unsigned PIX   = 4 * (MD + 1);
   localparam int unsigned LINE  = PIX * NPX;

   typedef struct {
      int unsigned len;
      logic        bank;
   } line_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       line_start;
   logic       stall;
   logic       cmp_en, agg_en, sel_en, wr_en, px_last;
   logic [9:0] proc_x;
   logic [5:0] d;
   logic       bank_sel, busy, pending, line_done;
   logic [7:0] overrun_cnt;

   int    total = 0;
   int    bad   = 0;
   line_t sb[$];
   logic  nb;

   sad_sweep_scheduler #(
      .IMG_WIDTH    (IMG_W),
      .MAX_DISPARITY(MD),
      .X_FIRST      (XF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .line_start (line_start),
      .stall      (stall),
      .cmp_en     (cmp_en),
      .agg_en     (agg_en),
      .sel_en     (sel_en),
      .wr_en      (wr_en),
      .px_last    (px_last),
      .proc_x     (proc_x),
      .d          (d),
      .bank_sel   (bank_sel),
      .busy       (busy),
      .pending    (pending),
      .line_done  (line_done),
      .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic push_line(input int unsigned len);
      line_t r;
      r.len  = len;
      r.bank = nb;
      sb.push_back(r);
      nb = ~nb;
   endtask

   task automatic pulse_ls();
      @(posedge clk); #1 line_start = 1'b1;
      @(posedge clk); #1 line_start = 1'b0;
   endtask

   // Returns at the negedge of the COMPARE cycle for (px, dd).
   task automatic goto(input string tag, input int px, input int dd);
      logic found = 1'b0;
      for (int i = 0; i < int'(LINE) + 200; i++) begin
         @(negedge clk);
         if (cmp_en && proc_x == 10'(px) && d == 6'(dd)) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, 32'(found), 1);
   endtask

   task automatic wait_done(input string tag);
      logic found = 1'b0;
      for (int i = 0; i < int'(LINE) + 200; i++) begin
         @(negedge clk);
         if (line_done) begin
            found = 1'b1;
            break;
         end
      end
      chk(tag, 32'(found), 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_flags"}, 32'({cmp_en, agg_en, sel_en, wr_en, px_last, line_done, busy, pending, bank_sel}), 0);
      chk({tag, "_x"}, 32'(proc_x), XF);
      chk({tag, "_d"}, 32'(d), 0);
      chk({tag, "_ovr"}, 32'(overrun_cnt), 0);
   endtask

   // Cycle monitor: per-cycle invariants plus line length, bank and pulse counts per line.
   initial begin
      logic        in_line = 1'b0;
      int unsigned line_cyc = 0, wr_cnt = 0, pl_cnt = 0;
      line_t       r;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_line = 1'b0;
         end else begin
            if (!in_line && cmp_en) begin
               in_line = 1'b1; line_cyc = 0; wr_cnt = 0; pl_cnt = 0;
            end
            if (in_line) line_cyc++;
            if (wr_en) wr_cnt++;
            if (px_last) pl_cnt++;
            chk("one_strobe", 32'(cmp_en) + 32'(agg_en) + 32'(sel_en) + 32'(wr_en), 32'(busy && !stall));
            chk("range", 32'(!busy || (int'(proc_x) >= int'(XF) && int'(proc_x) <= int'(XL) && int'(d) <= int'(MD))), 1);
            chk("px_last_def", 32'(px_last), 32'(wr_en && int'(d) == int'(MD)));
            chk("line_done_def", 32'(line_done), 32'(wr_en && int'(d) == int'(MD) && int'(proc_x) == int'(XL)));
            if (line_done) begin
               chk("sb_has_entry", 32'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  r = sb.pop_front();
                  chk("line_len", line_cyc, r.len);
                  chk("line_bank", 32'(bank_sel), 32'(r.bank));
                  chk("line_wr_cnt", wr_cnt, NPX * (MD + 1));
                  chk("line_px_last_cnt", pl_cnt, NPX);
               end
               in_line = 1'b0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; line_start = 1'b0; stall = 1'b0; nb = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outs("reset");
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_busy", 32'(busy), 0);

      // Single line from IDLE
      push_line(LINE);
      pulse_ls();
      @(negedge clk);
      chk("l1_cmp_next", 32'(cmp_en), 1);
      chk("l1_start_x", 32'(proc_x), XF);
      chk("l1_start_d", 32'(d), 0);
      chk("l1_no_pend", 32'(pending), 0);
      wait_done("l1_done_seen");
      @(negedge clk);
      chk("l1_idle", 32'(busy), 0);
      chk("l1_bank", 32'(bank_sel), 1);

      // Queued line starts back-to-back
      push_line(LINE);
      push_line(LINE);
      pulse_ls();
      repeat (1000) @(negedge clk);
      pulse_ls();
      @(negedge clk);
      chk("q_pend_set", 32'(pending), 1);
      wait_done("q_done1_seen");
      chk("q_busy_at_done", 32'(busy), 1);
      @(negedge clk);
      chk("q_b2b_cmp", 32'(cmp_en), 1);
      chk("q_b2b_busy", 32'(busy), 1);
      chk("q_pend_clr", 32'(pending), 0);
      chk("q_bank_mid", 32'(bank_sel), 0);
      wait_done("q_done2_seen");
      @(negedge clk);
      chk("q_idle", 32'(busy), 0);
      chk("q_bank_end", 32'(bank_sel), 1);

      // Ten-cycle stall during AGGREGATE at x=5, d=7
      push_line(LINE + 10);
      pulse_ls();
      goto("st_reach", 5, 7);
      @(posedge clk); #1 stall = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("st_strobes", 32'({cmp_en, agg_en, sel_en, wr_en, px_last, line_done}), 0);
         chk("st_pos", 32'({proc_x, d}), 32'({10'd5, 6'd7}));
      end
      @(posedge clk); #1 stall = 1'b0;
      @(negedge clk);
      chk("st_agg_resume", 32'(agg_en), 1);
      chk("st_pos_resume", 32'({proc_x, d}), 32'({10'd5, 6'd7}));
      wait_done("st_done_seen");

      // End-of-line start with a line already pending
      push_line(LINE);
      push_line(LINE);
      push_line(LINE);
      pulse_ls();
      pulse_ls();
      goto("e1_reach", XL, MD);
      @(posedge clk); @(posedge clk); @(posedge clk); #1 line_start = 1'b1;
      @(negedge clk);
      chk("e1_eol", 32'({line_done, pending}), 32'(2'b11));
      @(posedge clk); #1 line_start = 1'b0;
      @(negedge clk);
      chk("e1_b2b_cmp", 32'(cmp_en), 1);
      chk("e1_pend_kept", 32'(pending), 1);
      chk("e1_no_ovr", 32'(overrun_cnt), 0);
      wait_done("e1_next_done");
      @(negedge clk);
      chk("e2_start_cmp", 32'(cmp_en), 1);
      chk("e2_pend_clr", 32'(pending), 0);

      // End-of-line start with nothing pending; that line is later cut by reset
      goto("e2_reach", XL, MD);
      @(posedge clk); @(posedge clk); @(posedge clk); #1 line_start = 1'b1;
      @(negedge clk);
      chk("e2_eol", 32'({line_done, pending}), 32'(2'b10));
      @(posedge clk); #1 line_start = 1'b0;
      @(negedge clk);
      chk("e2_b2b_cmp", 32'(cmp_en), 1);
      chk("e2_pend_zero", 32'(pending), 0);
      chk("e2_busy", 32'(busy), 1);

      // Asynchronous reset mid-line
      goto("r_reach", 20, 0);
      chk("r_bank_before", 32'(bank_sel), 1);
      #2 rst = 1'b1;
      #1 chk_reset_outs("async_rst");
      nb = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("r_idle", 32'(busy), 0);

      // Restart after reset, then flood with starts to saturate the overrun counter
      push_line(LINE);
      push_line(LINE);
      pulse_ls();
      @(negedge clk);
      chk("r_restart_cmp", 32'(cmp_en), 1);
      chk("r_restart_pos", 32'({proc_x, d}), 32'({10'd1, 6'd0}));
      pulse_ls();
      @(negedge clk);
      chk("o_pend_set", 32'(pending), 1);
      chk("o_cnt0", 32'(overrun_cnt), 0);
      repeat (100) pulse_ls();
      @(negedge clk);
      chk("o_cnt100", 32'(overrun_cnt), 100);
      repeat (200) pulse_ls();
      @(negedge clk);
      chk("o_cnt_sat", 32'(overrun_cnt), 255);
      chk("o_pend_held", 32'(pending), 1);
      wait_done("o_done1_seen");
      wait_done("o_done2_seen");
      repeat (200) @(negedge clk);
      chk("o_final_idle", 32'({busy, pending}), 0);
      chk("o_final_cnt", 32'(overrun_cnt), 255);
      chk("o_final_bank", 32'(bank_sel), 0);
      chk("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
